t05_histogram_rmw: RTL and testbench

Parametrised character-frequency histogram that sits between the SPI byte receiver and the shared SRAM in the team 05 Huffman compression path. It accepts one symbol per handshake and performs a read-modify-write of that symbol's count word over an acknowledged SRAM port. It zero-fills the table before counting and reports total symbol count and distinct-symbol (leaf) count when the EOF symbol has been processed.

---
 rtl/t05_hist_pkg.sv | 27 ++
 rtl/t05_histogram_rmw.sv | 160 ++++++++++++++++
 tb/tb_t05_histogram_rmw.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t05_hist_pkg.sv
// Shared types and defaults for the Huffman histogram and the tree builder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package t05_hist_pkg;

  localparam int unsigned HIST_SYM_W   = 8;
  localparam int unsigned HIST_CNT_W   = 32;
  localparam logic [7:0]  HIST_EOF_SYM = 8'h1A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCEPT,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } hist_state_t;

  // Saturating +1 on the low w bits of v (w <= 64). Callers size-cast the
  // result back to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/t05_histogram_rmw.sv
// Symbol histogram: zero-fills a 2^SYM_W-entry SRAM table, then read-modify-writes one count per symbol.
// Latency: CLEAR 2^SYM_W cycles, 3 cycles per symbol with zero-wait ack (2 on a forwarding hit).
// Backpressure: sym_ready only in ACCEPT; SRAM requests are held unchanged until mem_ack.
//
// Ports: clk/rst (sync, active-high); start; sym_valid/sym_ready/sym_data symbol handshake;
//   mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ack acknowledged SRAM port;
//   busy, done (1-cycle pulse), total (saturating symbol count), distinct (new nonzero entries).
// Optional build macro: T05_HIST_FWD_EN forwards the last written count when a symbol repeats.
module t05_histogram_rmw
  import t05_hist_pkg::*;
#(
  parameter int unsigned      SYM_W   = HIST_SYM_W,
  parameter int unsigned      CNT_W   = HIST_CNT_W,
  parameter int unsigned      TOT_W   = 32,
  parameter logic [SYM_W-1:0] EOF_SYM = SYM_W'(HIST_EOF_SYM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [SYM_W-1:0] sym_data,
  output logic [SYM_W-1:0] mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [CNT_W-1:0] mem_wdata,
  input  logic [CNT_W-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy,
  output logic             done,
  output logic [TOT_W-1:0] total,
  output logic [SYM_W:0]   distinct
);

  hist_state_t      state_q, state_d;
  logic [SYM_W-1:0] clr_addr_q;
  logic [SYM_W-1:0] sym_q;
  logic [CNT_W-1:0] rdata_q;
  logic [CNT_W-1:0] wr_val;
  logic [TOT_W-1:0] total_q;
  logic [SYM_W:0]   distinct_q;
  logic             hit_q;     // current symbol's count came from the held entry
  logic             fwd_hit;

`ifdef T05_HIST_FWD_EN
  logic             fwd_vld_q;
  logic [SYM_W-1:0] fwd_addr_q;
  logic [CNT_W-1:0] fwd_val_q;

  // The held entry is only ever the previous symbol of this run, so a match
  // means back-to-back repeats; its SRAM copy is already up to date.
  assign fwd_hit = fwd_vld_q && (sym_data == fwd_addr_q);
`else
  assign fwd_hit = 1'b0;
`endif

  assign wr_val   = CNT_W'(sat_inc(64'(rdata_q), CNT_W));
  assign total    = total_q;
  assign distinct = distinct_q;

  always_comb begin
    state_d   = state_q;
    sym_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != ST_IDLE);
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        mem_wr   = 1'b1;
        mem_addr = clr_addr_q;
        if (mem_ack && (clr_addr_q == {SYM_W{1'b1}})) state_d = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        sym_ready = 1'b1;
        if (sym_valid) state_d = fwd_hit ? ST_WRITE : ST_READ;
      end
      ST_READ: begin
        mem_rd   = 1'b1;
        mem_addr = sym_q;
        if (mem_ack) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = sym_q;
        mem_wdata = wr_val;
        if (mem_ack) state_d = (sym_q == EOF_SYM) ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      sym_q      <= '0;
      rdata_q    <= '0;
      total_q    <= '0;
      distinct_q <= '0;
      hit_q      <= 1'b0;
`ifdef T05_HIST_FWD_EN
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_val_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            clr_addr_q <= '0;
            total_q    <= '0;
            distinct_q <= '0;
`ifdef T05_HIST_FWD_EN
            fwd_vld_q  <= 1'b0;
`endif
          end
        end
        ST_CLEAR: begin
          if (mem_ack) clr_addr_q <= clr_addr_q + SYM_W'(1);
        end
        ST_ACCEPT: begin
          if (sym_valid) begin
            sym_q <= sym_data;
            hit_q <= fwd_hit;
`ifdef T05_HIST_FWD_EN
            if (fwd_hit) rdata_q <= fwd_val_q;
`endif
          end
        end
        ST_READ: begin
          if (mem_ack) rdata_q <= mem_rdata;
        end
        ST_WRITE: begin
          if (mem_ack) begin
            total_q <= TOT_W'(sat_inc(64'(total_q), TOT_W));
            if ((rdata_q == '0) && !hit_q) distinct_q <= distinct_q + (SYM_W+1)'(1);
`ifdef T05_HIST_FWD_EN
            fwd_vld_q  <= 1'b1;
            fwd_addr_q <= sym_q;
            fwd_val_q  <= wr_val;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_histogram_rmw.sv
// Bench for t05_histogram_rmw: SRAM model with programmable/random ack delay and a
// count-table reference model built from the list of symbols sent.
module tb_t05_histogram_rmw;

`ifdef T05_HIST_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, sym_valid, sym_ready;
  logic [7:0]  sym_data, mem_addr;
  logic        mem_rd, mem_wr, mem_ack, busy, done;
  logic [31:0] mem_wdata, mem_rdata, total;
  logic [8:0]  distinct;

  always #5 clk = ~clk;

  t05_histogram_rmw dut (
    .clk(clk), .rst(rst), .start(start),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .total(total), .distinct(distinct)
  );

  // ---------------- SRAM model ----------------
  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
  logic [31:0] mem [256];
  int          rd_cnt [256];
  int          rd_total = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  bit          rand_delay = 1'b0;
  wr_t         wlog [$];

  assign mem_ack   = (mem_rd || mem_wr) && (wait_cnt >= cur_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_rd || mem_wr) begin
      if (mem_ack) begin
        wait_cnt  <= 0;
        cur_delay <= rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
        if (mem_wr) begin
          mem[mem_addr] = mem_wdata;
          wlog.push_back({mem_addr, mem_wdata});
        end else begin
          rd_cnt[mem_addr] = rd_cnt[mem_addr] + 1;
          rd_total = rd_total + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt  <= 0;
      cur_delay <= rand_delay ? int'($urandom_range(0, 2)) : ack_delay;
    end
  end

  // ---------------- protocol monitor (mid-cycle) ----------------
  int   done_cnt = 0, busy_cnt = 0, stall_err = 0, proto_err = 0, stall_cycles = 0;
  bit   p_stalled = 1'b0, p_rst = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [7:0]  p_addr = '0;
  logic [31:0] p_wdata = '0;

  always @(negedge clk) begin
    if (mem_rd && mem_wr) proto_err = proto_err + 1;
    if ((mem_rd || mem_wr) && sym_ready) proto_err = proto_err + 1;
    if (p_stalled && !p_rst) begin
      if (mem_rd !== p_rd || mem_wr !== p_wr || mem_addr !== p_addr || mem_wdata !== p_wdata)
        stall_err = stall_err + 1;
    end
    p_stalled = (mem_rd || mem_wr) && !mem_ack;
    if (p_stalled) stall_cycles = stall_cycles + 1;
    p_rd = mem_rd; p_wr = mem_wr; p_addr = mem_addr; p_wdata = mem_wdata; p_rst = rst;
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0]  sent [$];
  bit          pre_en = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [31:0] pre_v = '0;
  logic [31:0] exp_mem [256];
  int          exp_total, exp_distinct, exp_reads;

  // Final table = post-clear contents plus occurrences, saturating; distinct counts
  // symbols that were seen and whose post-clear entry was zero.
  function automatic void build_ref();
    int occ [256];
    longint unsigned base, v;
    for (int i = 0; i < 256; i++) occ[i] = 0;
    foreach (sent[k]) occ[sent[k]]++;
    exp_distinct = 0;
    for (int i = 0; i < 256; i++) begin
      base = (pre_en && pre_a == 8'(i)) ? longint'(pre_v) : 0;
      v = base + longint'(occ[i]);
      exp_mem[i] = (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
      if (occ[i] > 0 && base == 0) exp_distinct++;
    end
    exp_total = sent.size();
    exp_reads = 0;
    foreach (sent[k]) if (!FWD || k == 0 || sent[k] != sent[k-1]) exp_reads++;
  endfunction

  // ---------------- drivers ----------------
  int checks = 0, passes = 0;
  bit to_flag = 1'b0;

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (sym_ready !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
    if (sym_ready !== 1'b1) to_flag = 1'b1;
  endtask

  task automatic send_sym(input logic [7:0] s);
    sym_valid = 1'b1;
    sym_data  = s;
    wait_ready();
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
    if (done !== 1'b1) to_flag = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_seq();
    do_start();
    if (pre_en) begin
      wait_ready();
      mem[pre_a] = pre_v;
    end
    foreach (sent[k]) send_sym(sent[k]);
    wait_done();
    build_ref();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sym_ready !== 1'b0) $display("FAIL reset.sym_ready got %b want 0", sym_ready); else passes++;
    checks++; if (mem_rd !== 1'b0) $display("FAIL reset.mem_rd got %b want 0", mem_rd); else passes++;
    checks++; if (mem_wr !== 1'b0) $display("FAIL reset.mem_wr got %b want 0", mem_wr); else passes++;
    checks++; if (mem_addr !== 8'd0) $display("FAIL reset.mem_addr got %h want 00", mem_addr); else passes++;
    checks++; if (mem_wdata !== 32'd0) $display("FAIL reset.mem_wdata got %h want 0", mem_wdata); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset.busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset.done got %b want 0", done); else passes++;
    checks++; if (total !== 32'd0) $display("FAIL reset.total got %0d want 0", total); else passes++;
    checks++; if (distinct !== 9'd0) $display("FAIL reset.distinct got %0d want 0", distinct); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input string tag, input bit chk_busy);
    int d0, b0, r0;
    sent = '{8'h41, 8'h42, 8'h41, 8'h43, 8'h1A};
    pre_en = 1'b0; to_flag = 1'b0;
    d0 = done_cnt; b0 = busy_cnt; r0 = rd_total;
    run_seq();
    checks++; if (to_flag !== 1'b0) $display("FAIL %s.timeout got 1 want 0", tag); else passes++;
    checks++; if (mem[65] !== 32'd2) $display("FAIL %s.mem65 got %0d want 2", tag, mem[65]); else passes++;
    checks++; if (mem[66] !== 32'd1) $display("FAIL %s.mem66 got %0d want 1", tag, mem[66]); else passes++;
    checks++; if (mem[67] !== 32'd1) $display("FAIL %s.mem67 got %0d want 1", tag, mem[67]); else passes++;
    checks++; if (mem[26] !== 32'd1) $display("FAIL %s.mem26 got %0d want 1", tag, mem[26]); else passes++;
    checks++; if (total !== 32'd5) $display("FAIL %s.total got %0d want 5", tag, total); else passes++;
    checks++; if (distinct !== 9'd4) $display("FAIL %s.distinct got %0d want 4", tag, distinct); else passes++;
    checks++; if (done_cnt - d0 != 1) $display("FAIL %s.done_pulses got %0d want 1", tag, done_cnt - d0); else passes++;
    checks++; if (rd_total - r0 != 5) $display("FAIL %s.reads got %0d want 5", tag, rd_total - r0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL %s.busy_after got %b want 0", tag, busy); else passes++;
    if (chk_busy) begin
      checks++; if (busy_cnt - b0 != 272) $display("FAIL %s.busy_cycles got %0d want 272", tag, busy_cnt - b0); else passes++;
    end
  endtask

  task automatic test_clear();
    int w0, b0, bad;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_00FF;
    sent = '{8'h1A};
    pre_en = 1'b0; to_flag = 1'b0;
    w0 = wlog.size(); b0 = busy_cnt;
    do_start();
    sym_valid = 1'b1; sym_data = 8'h1A;
    repeat (100) @(posedge clk);
    #1;
    start = 1'b1;                 // must be ignored mid-CLEAR
    @(posedge clk); #1;
    start = 1'b0;
    send_sym(8'h1A);
    wait_done();
    build_ref();
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (w0 + i >= wlog.size() || wlog[w0+i].a !== 8'(i) || wlog[w0+i].d !== 32'd0) bad++;
    checks++; if (to_flag !== 1'b0) $display("FAIL clear.timeout got 1 want 0"); else passes++;
    checks++; if (wlog.size() - w0 != 257) $display("FAIL clear.writes got %0d want 257", wlog.size() - w0); else passes++;
    checks++; if (bad != 0) $display("FAIL clear.order bad_entries got %0d want 0", bad); else passes++;
    checks++; if (wlog.size() > w0 + 256 && wlog[w0+256] !== {8'h1A, 32'd1})
      $display("FAIL clear.eof_write got %h want 1a00000001", wlog[w0+256]); else passes++;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    checks++; if (bad != 0) $display("FAIL clear.table bad_entries got %0d want 0", bad); else passes++;
    checks++; if (busy_cnt - b0 != 260) $display("FAIL clear.busy_cycles got %0d want 260", busy_cnt - b0); else passes++;
    checks++; if (distinct !== 9'(exp_distinct)) $display("FAIL clear.distinct got %0d want %0d", distinct, exp_distinct); else passes++;
  endtask

  task automatic test_saturate();
    int w0;
    logic [31:0] last_d;
    sent = '{8'h41, 8'h1A};
    pre_en = 1'b1; pre_a = 8'd65; pre_v = 32'hFFFF_FFFF; to_flag = 1'b0;
    w0 = wlog.size();
    run_seq();
    pre_en = 1'b0;
    last_d = 32'h0;
    for (int i = w0; i < wlog.size(); i++) if (wlog[i].a == 8'd65) last_d = wlog[i].d;
    checks++; if (to_flag !== 1'b0) $display("FAIL sat.timeout got 1 want 0"); else passes++;
    checks++; if (last_d !== 32'hFFFF_FFFF) $display("FAIL sat.wdata got %h want ffffffff", last_d); else passes++;
    checks++; if (mem[65] !== exp_mem[65]) $display("FAIL sat.mem65 got %h want %h", mem[65], exp_mem[65]); else passes++;
    checks++; if (distinct !== 9'(exp_distinct)) $display("FAIL sat.distinct got %0d want %0d", distinct, exp_distinct); else passes++;
    checks++; if (total !== 32'(exp_total)) $display("FAIL sat.total got %0d want %0d", total, exp_total); else passes++;
  endtask

  task automatic test_stall();
    int s0, p0, c0;
    s0 = stall_err; p0 = proto_err; c0 = stall_cycles;
    ack_delay = 3;
    test_basic("stall", 1'b0);
    ack_delay = 0;
    checks++; if (stall_cycles <= c0) $display("FAIL stall.seen got %0d stall cycles want >0", stall_cycles - c0); else passes++;
    checks++; if (stall_err != s0) $display("FAIL stall.hold got %0d changes want 0", stall_err - s0); else passes++;
    checks++; if (proto_err != p0) $display("FAIL stall.proto got %0d errors want 0", proto_err - p0); else passes++;
  endtask

  task automatic test_fwd();
    int r65;
    sent = '{8'h41, 8'h41, 8'h41, 8'h1A};
    pre_en = 1'b0; to_flag = 1'b0;
    r65 = rd_cnt[65];
    run_seq();
    checks++; if (to_flag !== 1'b0) $display("FAIL fwd.timeout got 1 want 0"); else passes++;
    checks++; if (rd_cnt[65] - r65 != (FWD ? 1 : 3)) $display("FAIL fwd.reads65 got %0d want %0d", rd_cnt[65] - r65, FWD ? 1 : 3); else passes++;
    checks++; if (mem[65] !== 32'd3) $display("FAIL fwd.mem65 got %0d want 3", mem[65]); else passes++;
    checks++; if (total !== 32'd4) $display("FAIL fwd.total got %0d want 4", total); else passes++;
    checks++; if (distinct !== 9'd2) $display("FAIL fwd.distinct got %0d want 2", distinct); else passes++;
  endtask

  task automatic test_rst_mid();
    ack_delay = 0; to_flag = 1'b0;
    do_start();
    wait_ready();
    ack_delay = 100;
    sym_valid = 1'b1; sym_data = 8'h41;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_rd !== 1'b1) $display("FAIL rst_mid.stalled_rd got %b want 1", mem_rd); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_rd !== 1'b0) $display("FAIL rst_mid.mem_rd got %b want 0", mem_rd); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid.busy got %b want 0", busy); else passes++;
    checks++; if (mem_addr !== 8'd0) $display("FAIL rst_mid.mem_addr got %h want 00", mem_addr); else passes++;
    checks++; if (total !== 32'd0) $display("FAIL rst_mid.total got %0d want 0", total); else passes++;
    rst = 1'b0;
    ack_delay = 0;
    @(posedge clk); #1;
    test_basic("after_rst", 1'b1);
  endtask

  task automatic test_random();
    int len, d0, r0, bad;
    logic [7:0] s;
    rand_delay = 1'b1;
    for (int r = 0; r < 4; r++) begin
      sent.delete();
      len = $urandom_range(4, 24);
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 2) == 0) s = sent[k-1];
        else begin
          s = 8'($urandom_range(0, 255));
          if (s == 8'h1A) s = 8'h1B;
        end
        sent.push_back(s);
      end
      sent.push_back(8'h1A);
      pre_en = 1'b0; to_flag = 1'b0;
      d0 = done_cnt; r0 = rd_total;
      run_seq();
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
      checks++; if (to_flag !== 1'b0) $display("FAIL rand%0d.timeout got 1 want 0", r); else passes++;
      checks++; if (bad != 0) $display("FAIL rand%0d.table bad_entries got %0d want 0", r, bad); else passes++;
      checks++; if (total !== 32'(exp_total)) $display("FAIL rand%0d.total got %0d want %0d", r, total, exp_total); else passes++;
      checks++; if (distinct !== 9'(exp_distinct)) $display("FAIL rand%0d.distinct got %0d want %0d", r, distinct, exp_distinct); else passes++;
      checks++; if (rd_total - r0 != exp_reads) $display("FAIL rand%0d.reads got %0d want %0d", r, rd_total - r0, exp_reads); else passes++;
      checks++; if (done_cnt - d0 != 1) $display("FAIL rand%0d.done_pulses got %0d want 1", r, done_cnt - d0); else passes++;
    end
    rand_delay = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      rd_cnt[i] = 0;
    end
    test_reset();
    test_basic("basic", 1'b1);
    test_clear();
    test_saturate();
    test_stall();
    test_fwd();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached, %0d/%0d passed so far", passes, checks);
    $fatal(1);
  end

endmodule
